muldiv: RTL and testbench

- Iterative multiply/divide unit in the execute stage, beside the ALU.
- Takes the same rs/rt operands as the ALU and owns the architectural HI/LO registers.
- Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- HI/LO feed the writeback select mux downstream of the ALU result, for MFHI/MFLO. Control stalls the core on busy.

---
 rtl/muldiv.sv | 155 +++++++++++++++
 tb/tb_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers: shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_MUL_EN: mult/multu complete in one cycle via a combinational product.
module muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_dw(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic               is_div, neg_res, neg_rem;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH:0]     sum, trial;

  logic             sgn_in, accept_op;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign sgn_in    = ~op[0];
  assign accept_op = start && (state != RUN) && !op[2];
  assign mag_a_in  = magnitude(a, sgn_in);
  assign mag_b_in  = magnitude(b, sgn_in);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = apply_sign_dw((2*WIDTH)'(mag_a_in) * (2*WIDTH)'(mag_b_in),
                                   sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]));
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    trial   = '0;
    if (is_div) begin
      trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
      if (!trial[WIDTH]) acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  // Final step result; a zero divisor leaves remainder = |a| and forces an all-ones quotient
  always_comb begin
    prod = apply_sign_dw(acc_nxt, neg_res);
    if (is_div) begin
      res_lo = (mag_b == '0) ? '1 : apply_sign(acc_nxt[WIDTH-1:0], neg_res);
      res_hi = apply_sign(acc_nxt[2*WIDTH-1:WIDTH], neg_rem);
    end else begin
      {res_hi, res_lo} = prod;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_op) begin
      mag_a   <= mag_a_in;
      mag_b   <= mag_b_in;
      is_div  <= op[1];
      neg_res <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem <= sgn_in & a[WIDTH-1];
      acc     <= op[1] ? {{WIDTH{1'b0}}, mag_a_in} : {{WIDTH{1'b0}}, mag_b_in};
    end else if (state == RUN) begin
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                state    <= DONE;
                done     <= 1'b1;
                {hi, lo} <= fast_prod;
`else
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= '0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                state <= RUN;
                busy  <= 1'b1;
                cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus random operands against an arithmetic model.
module tb_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, last_done = 0;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  muldiv #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: r = 64'(sx * sy);
      3'd1: r = {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  // Issues one arithmetic op now (caller is #1 after an edge) and follows it to done
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input bit inject);
    logic [63:0] e;
    int n, nb, lat;
    bit hold_ok;
    e   = ref_op(o, av, bv);
    lat = (!o[1] && FAST) ? 0 : W;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0; nb = 0; hold_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy) nb++;
      if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
      if (inject && n == 5) begin start = 1'b1; op = 3'b101; a = $urandom; end
      else if (inject && n == 6) begin op = 3'b000; b = $urandom; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    last_done = cyc;
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busycyc"}, nb, lat);
    if (lat > 0) chk({tag, "_hold"}, hold_ok, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_hi"}, hi, e[63:32]);
    chk({tag, "_lo"}, lo, e[31:0]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int prev;
    bit quiet;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); idle_cycle();
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0); idle_cycle();
    run_op("mult_fast_vec", 3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0); idle_cycle();
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0); idle_cycle();
    run_op("divu", 3'd3, 32'h0000_0007, 32'h0000_0002, 1'b0); idle_cycle();
    run_op("div_by0", 3'd2, 32'h0000_0005, 32'h0000_0000, 1'b0); idle_cycle();
    run_op("div_by0_neg", 3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0); idle_cycle();
    run_op("divu_by0", 3'd3, 32'h8765_4321, 32'h0000_0000, 1'b0); idle_cycle();
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle_cycle();
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0); idle_cycle();

    // Back-to-back: second start lands in the first op's done cycle
    run_op("b2b_first", 3'd2, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
    prev = last_done;
    run_op("b2b_second", 3'd3, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    chk("b2b_gap", last_done - prev, W + 1);
    idle_cycle();

    // mthi / mtlo / illegal op in IDLE
    start = 1'b1; op = 3'b100; a = 32'h0000_1234;
    @(posedge clk); #1; start = 1'b0;
    exp_hi = 32'h0000_1234;
    chk("mthi_hi", hi, exp_hi);
    chk("mthi_lo", lo, exp_lo);
    chk("mthi_done", {busy, done}, 2'b00);
    start = 1'b1; op = 3'b101; a = 32'hCAFE_F00D;
    @(posedge clk); #1; start = 1'b0;
    exp_lo = 32'hCAFE_F00D;
    chk("mtlo", {hi, lo}, {exp_hi, exp_lo});
    start = 1'b1; op = 3'b110; a = 32'h1111_1111; b = 32'h2222_2222;
    @(posedge clk); #1; op = 3'b111;
    @(posedge clk); #1; start = 1'b0;
    chk("illegal_hilo", {hi, lo}, {exp_hi, exp_lo});
    chk("illegal_ctl", {busy, done}, 2'b00);

    // Starts during RUN are ignored
    run_op("inject_divu", 3'd3, 32'h0000_0007, 32'h0000_0002, 1'b1); idle_cycle();
    run_op("inject_mult", 3'd0, 32'hFFFF_FFF9, 32'h0000_0003, 1'b1); idle_cycle();

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
      if (i % 3 != 0) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset mid-divide
    start = 1'b1; op = 3'b011; a = 32'hFFFF_0000; b = 32'h0000_0003;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hilo", {hi, lo}, 64'h0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk) rst_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) quiet = 1'b0;
    end
    chk("arst_quiet", quiet, 1);
    chk("arst_hold", {hi, lo}, 64'h0);

    run_op("post_rst_divu", 3'd3, 32'h0000_0007, 32'h0000_0002, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
